// File: rtl/mips_arb_pkg.sv
// Shared types for the MIPS data-memory arbiter.
//
// Contents:
//   arb_state_e   arbitration FSM states (IDLE, OWN_M0, OWN_M1)
//   master_e      master index (M0 = CPU data port, M1 = aux loader/debug port)
//   burst_width   width of a burst counter able to hold 0..max_burst
//   BURST_W       counter width for the default MAX_BURST of 4
package mips_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN_M0 = 2'd1,
        OWN_M1 = 2'd2
    } arb_state_e;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_e;

    localparam int unsigned MAX_BURST_DEFAULT = 4;

    function automatic int unsigned burst_width(input int unsigned max_burst);
        return $clog2(max_burst + 1);
    endfunction

    localparam int unsigned BURST_W = $clog2(MAX_BURST_DEFAULT + 1);

endpackage

// File: rtl/mips_arb_rr_pick.sv
// Combinational grant selection for the two-master data-memory arbiter.
//
// Ports:
//   req        in  [1:0]     request per master (bit 0 = M0, bit 1 = M1)
//   state      in  arb_state_e  current owner state
//   last       in  master_e  most recent owner that gave up the bus
//   burst_cnt  in  [CNT_W-1:0]  consecutive grants to the current owner
//   grant      out [1:0]     one-hot grant, or zero when nobody requests
module mips_arb_rr_pick
    import mips_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic [1:0]       req,
    input  arb_state_e       state,
    input  master_e          last,
    input  logic [CNT_W-1:0] burst_cnt,
    output logic [1:0]       grant
);

    logic cap_hit;

    assign cap_hit = (burst_cnt >= CNT_W'(MAX_BURST));

    always_comb begin
        grant = 2'b00;
        unique case (state)
            IDLE: begin
                // Tie goes to whoever did not own the bus most recently.
                if (req == 2'b11) begin
                    grant = (last == M1) ? 2'b01 : 2'b10;
                end else begin
                    grant = req;
                end
            end
            OWN_M0: begin
                if (req[0] && (!req[1] || !cap_hit)) begin
                    grant = 2'b01;
                end else if (req[1]) begin
                    grant = 2'b10;
                end
            end
            OWN_M1: begin
                if (req[1] && (!req[0] || !cap_hit)) begin
                    grant = 2'b10;
                end else if (req[0]) begin
                    grant = 2'b01;
                end
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mips_data_mem_arbiter.sv
// Two-master arbiter sharing one data memory between the CPU data port (M0)
// and an auxiliary loader/debug port (M1). Sticky round-robin with a burst
// cap; the granted master's address/data/strobes are muxed onto the memory
// and read data is returned one cycle after the grant with a valid pulse.
//
// Ports:
//   clk, reset (async, active low), clk_enable (low freezes arbitration)
//   m{0,1}_read/write/address/writedata   master requests
//   m{0,1}_waitrequest                    request present but not issued
//   m{0,1}_readdata/rvalid                read return to the owning master
//   mem_address/writedata/write/read      memory side, driven by the grantee
//   mem_readdata                          memory data, cycle after mem_read
//
// Optional build macro DMEM_ARB_STATS_EN adds m0_grant_cnt, m1_grant_cnt and
// contend_cnt (32-bit wrapping counters). Arbitration is identical without it.
module mips_data_mem_arbiter
    import mips_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,

    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_rvalid,

    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_rvalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_readdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]       m0_grant_cnt,
    output logic [31:0]       m1_grant_cnt,
    output logic [31:0]       contend_cnt
`endif
);

    localparam int unsigned CNT_W = burst_width(MAX_BURST);

    arb_state_e       state_q, state_d;
    master_e          last_q, last_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic             rd_pend_q, rd_pend_d;
    master_e          rd_owner_q, rd_owner_d;

    logic [1:0] req;
    logic [1:0] grant;
    logic [1:0] issue;

    assign req   = {m1_read | m1_write, m0_read | m0_write};
    assign issue = grant & {2{clk_enable}};

    mips_arb_rr_pick #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_pick (
        .req       (req),
        .state     (state_q),
        .last      (last_q),
        .burst_cnt (burst_q),
        .grant     (grant)
    );

    // ---------------------------------------------------------------------
    // FSM state register (frozen while clk_enable is low)
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= M1;      // so M0 wins the first tie
            burst_q <= '0;
        end else if (clk_enable) begin
            state_q <= state_d;
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        burst_d = burst_q;
        if (grant[0]) begin
            if (state_q == OWN_M0) begin
                if (burst_q < CNT_W'(MAX_BURST)) begin
                    burst_d = burst_q + CNT_W'(1);
                end
            end else begin
                if (state_q == OWN_M1) begin
                    last_d = M1;
                end
                state_d = OWN_M0;
                burst_d = CNT_W'(1);
            end
        end else if (grant[1]) begin
            if (state_q == OWN_M1) begin
                if (burst_q < CNT_W'(MAX_BURST)) begin
                    burst_d = burst_q + CNT_W'(1);
                end
            end else begin
                if (state_q == OWN_M0) begin
                    last_d = M0;
                end
                state_d = OWN_M1;
                burst_d = CNT_W'(1);
            end
        end else begin
            if (state_q == OWN_M0) begin
                last_d = M0;
            end else if (state_q == OWN_M1) begin
                last_d = M1;
            end
            state_d = IDLE;
            burst_d = '0;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs: memory mux and wait requests
    // ---------------------------------------------------------------------
    always_comb begin
        mem_address   = '0;
        mem_writedata = '0;
        mem_write     = 1'b0;
        mem_read      = 1'b0;
        if (issue[0]) begin
            mem_address   = m0_address;
            mem_writedata = m0_writedata;
            mem_write     = m0_write;
            mem_read      = m0_read & ~m0_write;  // write wins on a read+write
        end else if (issue[1]) begin
            mem_address   = m1_address;
            mem_writedata = m1_writedata;
            mem_write     = m1_write;
            mem_read      = m1_read & ~m1_write;
        end
    end

    assign m0_waitrequest = req[0] & ~issue[0];
    assign m1_waitrequest = req[1] & ~issue[1];

    // ---------------------------------------------------------------------
    // Read-return pipeline. Not gated by clk_enable so a read issued just
    // before the enable drops still gets its rvalid pulse.
    // ---------------------------------------------------------------------
    assign rd_pend_d  = mem_read;
    assign rd_owner_d = issue[1] ? M1 : M0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= M0;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign m0_rvalid   = rd_pend_q & (rd_owner_q == M0);
    assign m1_rvalid   = rd_pend_q & (rd_owner_q == M1);
    assign m0_readdata = m0_rvalid ? mem_readdata : '0;
    assign m1_readdata = m1_rvalid ? mem_readdata : '0;

`ifdef DMEM_ARB_STATS_EN
    // ---------------------------------------------------------------------
    // Statistics counters (wrap at 2^32)
    // ---------------------------------------------------------------------
    logic [31:0] m0_cnt_q, m1_cnt_q, contend_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m0_cnt_q  <= '0;
            m1_cnt_q  <= '0;
            contend_q <= '0;
        end else begin
            if (issue[0]) begin
                m0_cnt_q <= m0_cnt_q + 32'd1;
            end
            if (issue[1]) begin
                m1_cnt_q <= m1_cnt_q + 32'd1;
            end
            if (clk_enable && (req == 2'b11)) begin
                contend_q <= contend_q + 32'd1;
            end
        end
    end

    assign m0_grant_cnt = m0_cnt_q;
    assign m1_grant_cnt = m1_cnt_q;
    assign contend_cnt  = contend_q;
`endif

`ifndef SYNTHESIS
    // A simultaneous read and write from one master drops the read.
    always @(posedge clk) begin
        if (reset && issue[0] && m0_read && m0_write) begin
            $error("mips_data_mem_arbiter: M0 read and write in the same cycle, read dropped");
        end
        if (reset && issue[1] && m1_read && m1_write) begin
            $error("mips_data_mem_arbiter: M1 read and write in the same cycle, read dropped");
        end
    end
`endif

endmodule

// File: tb/tb_mips_data_mem_arbiter.sv
// Self-checking bench for mips_data_mem_arbiter (default MAX_BURST = 4).
// Read returns are predicted into a scoreboard queue when a read is driven
// and popped by a monitor when an rvalid pulse appears.
module tb_mips_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_address, m0_writedata, m1_address, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest, m0_rvalid, m1_rvalid;
    logic [31:0] m0_readdata, m1_readdata;
    logic [31:0] mem_address, mem_writedata;
    logic        mem_write, mem_read;
    logic [31:0] mem_readdata = 32'h0;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] m0_grant_cnt, m1_grant_cnt, contend_cnt;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        owner;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    mips_data_mem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .clk_enable     (clk_enable),
        .m0_read        (m0_read),
        .m0_write       (m0_write),
        .m0_address     (m0_address),
        .m0_writedata   (m0_writedata),
        .m0_waitrequest (m0_waitrequest),
        .m0_readdata    (m0_readdata),
        .m0_rvalid      (m0_rvalid),
        .m1_read        (m1_read),
        .m1_write       (m1_write),
        .m1_address     (m1_address),
        .m1_writedata   (m1_writedata),
        .m1_waitrequest (m1_waitrequest),
        .m1_readdata    (m1_readdata),
        .m1_rvalid      (m1_rvalid),
        .mem_address    (mem_address),
        .mem_writedata  (mem_writedata),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_readdata   (mem_readdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .m0_grant_cnt   (m0_grant_cnt),
        .m1_grant_cnt   (m1_grant_cnt),
        .contend_cnt    (contend_cnt)
`endif
    );

    // Synchronous-read data memory
    always @(posedge clk) begin
        if (mem_write === 1'b1) mem[mem_address[7:2]] <= mem_writedata;
        if (mem_read === 1'b1)  mem_readdata <= mem[mem_address[7:2]];
    end

    // Scoreboard monitor: every rvalid pulse must match the oldest prediction
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (m0_rvalid === 1'b1 || m1_rvalid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_rvalid: got m0_rvalid=%b m1_rvalid=%b, required no pulse",
                             m0_rvalid, m1_rvalid);
                end else begin
                    mon_e = sb.pop_front();
                    if (m0_rvalid !== ~mon_e.owner || m1_rvalid !== mon_e.owner ||
                        (mon_e.owner ? m1_readdata : m0_readdata) !== mon_e.data) begin
                        errors++;
                        $display("FAIL sb_read_return: got rv0=%b rv1=%b rd0=%h rd1=%h, required owner M%0d data %h",
                                 m0_rvalid, m1_rvalid, m0_readdata, m1_readdata, mon_e.owner, mon_e.data);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_read = 0; m0_write = 0; m0_address = 0; m0_writedata = 0;
        m1_read = 0; m1_write = 0; m1_address = 0; m1_writedata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        clk_enable = 1'b1;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        clk_enable = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_read, mem_write, m0_waitrequest, m1_waitrequest, m0_rvalid, m1_rvalid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b, required 000000",
                     {mem_read, mem_write, m0_waitrequest, m1_waitrequest, m0_rvalid, m1_rvalid});
        end
        checks++;
        if ({mem_address, mem_writedata, m0_readdata, m1_readdata} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wd=%h rd0=%h rd1=%h, required all 0",
                     mem_address, mem_writedata, m0_readdata, m1_readdata);
        end
        tick();
        reset = 1'b1;
    endtask

    task automatic test_single_read();
        m0_read = 1; m0_address = 32'h10;
        @(negedge clk);
        checks++;
        if (m0_waitrequest !== 1'b0) begin
            errors++; $display("FAIL single_waitreq: got %b, required 0", m0_waitrequest);
        end
        checks++;
        if (mem_read !== 1'b1 || mem_address !== 32'h10) begin
            errors++; $display("FAIL single_mem_read: got rd=%b addr=%h, required rd=1 addr=00000010",
                               mem_read, mem_address);
        end
        sb.push_back({1'b0, 32'hDEADBEEF});
        tick();
        m0_read = 0; m0_address = 0;
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b1 || m0_readdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_rvalid: got rv=%b data=%h, required rv=1 data=deadbeef",
                               m0_rvalid, m0_readdata);
        end
        checks++;
        if (m1_rvalid !== 1'b0 || m1_readdata !== 32'h0) begin
            errors++; $display("FAIL single_other: got m1_rvalid=%b m1_readdata=%h, required 0 and 0",
                               m1_rvalid, m1_readdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b0) begin
            errors++; $display("FAIL single_pulse_width: got m0_rvalid=%b, required 0", m0_rvalid);
        end
        tick();
    endtask

    task automatic test_burst_contention();
        logic owner;
        do_reset();
        m0_write = 1; m0_address = 32'h40; m0_writedata = 32'h1000;
        m1_write = 1; m1_address = 32'h80; m1_writedata = 32'h2000;
        for (int k = 0; k < 16; k++) begin
            owner = ((k / 4) % 2) != 0;
            @(negedge clk);
            checks++;
            if (m0_waitrequest !== owner || m1_waitrequest !== ~owner) begin
                errors++;
                $display("FAIL burst_waitreq[%0d]: got wr0=%b wr1=%b, required owner M%0d",
                         k, m0_waitrequest, m1_waitrequest, owner);
            end
            checks++;
            if (mem_write !== 1'b1 || mem_read !== 1'b0 ||
                mem_address !== (owner ? 32'h80 : 32'h40) ||
                mem_writedata !== (owner ? 32'h2000 + k : 32'h1000 + k)) begin
                errors++;
                $display("FAIL burst_mem[%0d]: got wr=%b rd=%b addr=%h wd=%h, required owner M%0d",
                         k, mem_write, mem_read, mem_address, mem_writedata, owner);
            end
            tick();
            m0_writedata = 32'h1000 + k + 1;
            m1_writedata = 32'h2000 + k + 1;
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_write_then_read();
        do_reset();
        // Make M0 the last owner so the next tie goes to M1
        m0_write = 1; m0_address = 32'h30; m0_writedata = 32'h1;
        tick();
        idle_inputs();
        tick();
        m1_write = 1; m1_address = 32'h20; m1_writedata = 32'h55;
        m0_read = 1; m0_address = 32'h20;
        @(negedge clk);
        checks++;
        if (m1_waitrequest !== 1'b0 || m0_waitrequest !== 1'b1) begin
            errors++; $display("FAIL wr_rd_first_grant: got wr0=%b wr1=%b, required wr0=1 wr1=0",
                               m0_waitrequest, m1_waitrequest);
        end
        checks++;
        if (mem_write !== 1'b1 || mem_address !== 32'h20 || mem_writedata !== 32'h55) begin
            errors++; $display("FAIL wr_rd_mem_write: got wr=%b addr=%h wd=%h, required 1 00000020 00000055",
                               mem_write, mem_address, mem_writedata);
        end
        tick();
        m1_write = 0;
        @(negedge clk);
        checks++;
        if (m0_waitrequest !== 1'b0 || mem_read !== 1'b1 || mem_address !== 32'h20) begin
            errors++; $display("FAIL wr_rd_read_grant: got wr0=%b rd=%b addr=%h, required 0 1 00000020",
                               m0_waitrequest, mem_read, mem_address);
        end
        sb.push_back({1'b0, 32'h55});
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b1 || m0_readdata !== 32'h55) begin
            errors++; $display("FAIL wr_rd_data: got rv=%b data=%h, required 1 00000055",
                               m0_rvalid, m0_readdata);
        end
        tick();
    endtask

    task automatic test_clk_enable();
        logic exp_owner [0:7];
        // Pending read return survives the enable dropping
        do_reset();
        m0_read = 1; m0_address = 32'h10;
        sb.push_back({1'b0, 32'hDEADBEEF});
        tick();
        idle_inputs();
        clk_enable = 1'b0;
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b1 || m0_readdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL ce_pending_rvalid: got rv=%b data=%h, required 1 deadbeef",
                               m0_rvalid, m0_readdata);
        end
        tick();
        // Freeze in the middle of an M0 burst
        do_reset();
        exp_owner = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        m0_write = 1; m0_address = 32'h44; m0_writedata = 32'h11;
        m1_write = 1; m1_address = 32'h84; m1_writedata = 32'h22;
        for (int k = 0; k < 11; k++) begin
            clk_enable = !(k >= 2 && k < 5);
            @(negedge clk);
            checks++;
            if (!clk_enable) begin
                if (mem_write !== 1'b0 || mem_read !== 1'b0 ||
                    m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
                    errors++;
                    $display("FAIL ce_frozen[%0d]: got wr=%b rd=%b wr0=%b wr1=%b, required 0 0 1 1",
                             k, mem_write, mem_read, m0_waitrequest, m1_waitrequest);
                end
            end else begin
                if (m0_waitrequest !== exp_owner[k < 2 ? k : k - 3] ||
                    m1_waitrequest !== ~exp_owner[k < 2 ? k : k - 3] || mem_write !== 1'b1) begin
                    errors++;
                    $display("FAIL ce_owner[%0d]: got wr0=%b wr1=%b mem_write=%b, required owner M%0d",
                             k, m0_waitrequest, m1_waitrequest, mem_write, exp_owner[k < 2 ? k : k - 3]);
                end
            end
            tick();
        end
        idle_inputs();
        clk_enable = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        m0_read = 1; m0_address = 32'h10;
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1) begin
            errors++; $display("FAIL rst_read_issue: got mem_read=%b, required 1", mem_read);
        end
        tick();
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b0 || m0_readdata !== 32'h0) begin
            errors++; $display("FAIL rst_read_discard: got rv=%b data=%h, required 0 0",
                               m0_rvalid, m0_readdata);
        end
        tick();
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
                errors++; $display("FAIL rst_no_pulse[%0d]: got rv0=%b rv1=%b, required 0 0",
                                   k, m0_rvalid, m1_rvalid);
            end
            tick();
        end
        m0_write = 1; m0_address = 32'h48;
        m1_write = 1; m1_address = 32'h88;
        @(negedge clk);
        checks++;
        if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin
            errors++; $display("FAIL rst_first_tie: got wr0=%b wr1=%b, required 0 1",
                               m0_waitrequest, m1_waitrequest);
        end
        tick();
        idle_inputs();
        tick();
    endtask

`ifdef DMEM_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        m0_write = 1; m0_address = 32'h4C;
        m1_write = 1; m1_address = 32'h8C;
        repeat (10) tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (m0_grant_cnt !== 32'd6 || m1_grant_cnt !== 32'd4 || contend_cnt !== 32'd10) begin
            errors++; $display("FAIL stats_counts: got m0=%0d m1=%0d cont=%0d, required 6 4 10",
                               m0_grant_cnt, m1_grant_cnt, contend_cnt);
        end
        tick();
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) mem[i] <= 32'hA5A50000 | i;
        mem[4] <= 32'hDEADBEEF;
        #1;
        test_reset();
        test_single_read();
        test_burst_contention();
        test_write_then_read();
        test_clk_enable();
        test_reset_mid_read();
`ifdef DMEM_ARB_STATS_EN
        test_stats();
`endif
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_drained: got %0d outstanding reads, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
